// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Purely compile-time; no logic.
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 32;

    // Ceiling log2; clog2(1) = 0, clog2(32) = 5, clog2(33) = 6.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Low bit of port slot 'port' in a packed vector of 'width'-bit slots.
    function automatic int port_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: per-register busy bits, population count, per-port hazard flags.
// Latency: busy/busy_cnt update on the clk edge; rd_busy is combinational from state and current writeback.
// Backpressure: none accepted; stalls are reported upward through rd_busy only.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = clog2(DEPTH),
    parameter int CW       = clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_rd,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_busy,
    output logic [CW-1:0]        busy_cnt
);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic             set_vld;
    logic             clr_vld;
    logic             cnt_inc;
    logic             cnt_dec;

    assign set_vld = iss_en && !((ZERO_REG != 0) && (iss_rd == '0));
    assign clr_vld = wr_en  && !((ZERO_REG != 0) && (wr_addr == '0));

    // A set on the retiring register supersedes its clear, so no decrement then.
    assign cnt_inc = set_vld && !busy[iss_rd];
    assign cnt_dec = clr_vld && busy[wr_addr] && !(set_vld && (iss_rd == wr_addr));

    always_comb begin
        busy_nxt = busy;
        for (int r = 0; r < DEPTH; r++) begin
            if (set_vld && (iss_rd == AW'(r))) begin
                busy_nxt[r] = 1'b1;
            end else if (clr_vld && (wr_addr == AW'(r))) begin
                busy_nxt[r] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy <= busy_nxt;
            case ({cnt_inc, cnt_dec})
                2'b10:   busy_cnt <= busy_cnt + CW'(1);
                2'b01:   busy_cnt <= busy_cnt - CW'(1);
                default: busy_cnt <= busy_cnt;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_haz
        logic [AW-1:0] src;
        assign src        = rd_addr[port_lo(g, AW) +: AW];
        assign rd_busy[g] = busy[src] && !(wr_en && (wr_addr == src));
    end

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with write-to-read bypass and pending-write scoreboard (trace: REG_FILE_SB_TRACE_EN).
// Latency: reads are combinational (zero cycles); writes and scoreboard commit on the clk edge.
// Backpressure: stall asserts when a requesting read port's source has an unbypassed outstanding producer.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_RD*clog2(DEPTH)-1:0]          rd_addr,
    input  logic [NUM_RD-1:0]                       rd_req,
    output logic [NUM_RD*DATA_W-1:0]                rd_data,
    output logic [NUM_RD-1:0]                       rd_busy,
    output logic                                    stall,
    input  logic                                    wr_en,
    input  logic [clog2(DEPTH)-1:0]                 wr_addr,
    input  logic [DATA_W-1:0]                       wr_data,
    input  logic                                    iss_en,
    input  logic [clog2(DEPTH)-1:0]                 iss_rd,
    output logic [clog2(DEPTH+1)-1:0]               busy_cnt
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_commit;

    assign wr_commit = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else if (wr_commit) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0]     src;
        logic [DATA_W-1:0] rdat;

        assign src = rd_addr[port_lo(g, AW) +: AW];

        // wr_commit already excludes the zero register, so it never bypasses.
        always_comb begin
            if ((ZERO_REG != 0) && (src == '0)) begin
                rdat = '0;
            end else if (wr_commit && (wr_addr == src)) begin
                rdat = wr_data;
            end else begin
                rdat = mem[src];
            end
        end

        assign rd_data[port_lo(g, DATA_W) +: DATA_W] = rdat;
    end

    reg_file_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG),
        .AW       (AW),
        .CW       (CW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .busy_cnt (busy_cnt)
    );

    assign stall = |(rd_req & rd_busy);

`ifdef REG_FILE_SB_TRACE_EN
    always @(posedge clk) begin
        if (rst) begin
            $display("%0t regfile reset", $time);
        end else if (wr_commit) begin
            $display("%0t regfile wr addr=%0d old=%h new=%h busy_cnt=%0d",
                     $time, wr_addr, mem[wr_addr], wr_data, busy_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb with default parameters (32x32, two read ports, zero register).
module tb_reg_file_sb;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [1:0]  rd_req;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        stall;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic [5:0]  busy_cnt;

    int n_chk;
    int n_pass;

    reg_file_sb dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .stall    (stall),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are then changed 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        rst     = 1'b1;
        rd_addr = '0;
        rd_req  = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        iss_en  = 1'b0;
        iss_rd  = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        set_rd(5'd1, 5'd31);
        #1;
        chk("rst_rd0", rd_data[31:0], 32'h0);
        chk("rst_rd1", rd_data[63:32], 32'h0);
        chk("rst_cnt", 32'(busy_cnt), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_busy", 32'(rd_busy), 32'd0);
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a), 5'(31 - a));
            #1;
            chk("rst_sweep0", rd_data[31:0], 32'h0);
            chk("rst_sweep1", rd_data[63:32], 32'h0);
        end

        // Same-cycle bypass, then stored value
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000_000C;
        set_rd(5'd5, 5'd4);
        #1;
        chk("byp_same", rd_data[31:0], 32'h0000_000C);
        chk("byp_other", rd_data[63:32], 32'h0);
        tick();
        wr_en = 1'b0;
        #1;
        chk("byp_held", rd_data[31:0], 32'h0000_000C);

        // Zero register: writes dropped, never busy
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        set_rd(5'd0, 5'd0);
        #1;
        chk("zero_nobyp", rd_data[31:0], 32'h0);
        tick();
        wr_en = 1'b0;
        #1;
        chk("zero_rd0", rd_data[31:0], 32'h0);
        chk("zero_rd1", rd_data[63:32], 32'h0);
        iss_en = 1'b1; iss_rd = 5'd0;
        tick();
        iss_en = 1'b0;
        #1;
        chk("zero_cnt", 32'(busy_cnt), 32'd0);

        // Hazard: issue to 3, read with and without request, resolve by writeback
        iss_en = 1'b1; iss_rd = 5'd3;
        tick();
        iss_en = 1'b0;
        set_rd(5'd0, 5'd3);
        #1;
        chk("haz_cnt1", 32'(busy_cnt), 32'd1);
        chk("haz_noreq_busy", 32'(rd_busy), 32'h2);
        chk("haz_noreq_stall", 32'(stall), 32'd0);
        rd_req = 2'b10;
        #1;
        chk("haz_busy", 32'(rd_busy), 32'h2);
        chk("haz_stall", 32'(stall), 32'd1);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h5;
        #1;
        chk("haz_byp_stall", 32'(stall), 32'd0);
        chk("haz_byp_busy", 32'(rd_busy), 32'h0);
        chk("haz_byp_data", rd_data[63:32], 32'h5);
        tick();
        wr_en = 1'b0; rd_req = 2'b00;
        #1;
        chk("haz_cnt0", 32'(busy_cnt), 32'd0);
        chk("haz_data", rd_data[63:32], 32'h5);

        // Same-cycle set and clear on 6: set wins
        iss_en = 1'b1; iss_rd = 5'd6;
        tick();
        iss_en = 1'b0;
        #1;
        chk("sc_cnt1", 32'(busy_cnt), 32'd1);
        iss_en = 1'b1; iss_rd = 5'd6;
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
        tick();
        iss_en = 1'b0; wr_en = 1'b0;
        set_rd(5'd6, 5'd7);
        rd_req = 2'b01;
        #1;
        chk("sc_same_cnt", 32'(busy_cnt), 32'd1);
        chk("sc_same_busy", 32'(rd_busy), 32'h1);
        chk("sc_same_stall", 32'(stall), 32'd1);
        chk("sc_same_data", rd_data[31:0], 32'h66);

        // Set on 7 with clear on 6: busy moves, count unchanged
        rd_req = 2'b00;
        iss_en = 1'b1; iss_rd = 5'd7;
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h77;
        tick();
        iss_en = 1'b0; wr_en = 1'b0;
        rd_req = 2'b11;
        #1;
        chk("sc_move_cnt", 32'(busy_cnt), 32'd1);
        chk("sc_move_busy", 32'(rd_busy), 32'h2);
        chk("sc_move_stall", 32'(stall), 32'd1);
        chk("sc_move_data", rd_data[31:0], 32'h77);
        rd_req = 2'b00;

        // Reach four busy registers, then reset with competing write and issue
        for (int r = 10; r < 13; r++) begin
            iss_en = 1'b1; iss_rd = 5'(r);
            tick();
        end
        iss_en = 1'b0;
        #1;
        chk("mid_cnt4", 32'(busy_cnt), 32'd4);
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hDEAD_BEEF;
        iss_en = 1'b1; iss_rd = 5'd13;
        tick();
        rst = 1'b0; wr_en = 1'b0; iss_en = 1'b0;
        set_rd(5'd9, 5'd6);
        rd_req = 2'b11;
        #1;
        chk("mid_cnt0", 32'(busy_cnt), 32'd0);
        chk("mid_stall", 32'(stall), 32'd0);
        chk("mid_rd9", rd_data[31:0], 32'h0);
        chk("mid_rd6", rd_data[63:32], 32'h0);
        set_rd(5'd7, 5'd13);
        #1;
        chk("mid_busy", 32'(rd_busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
